// File: rtl/c2sif_pkg.sv
// c2sif shared definitions: function codes, ret codes, master FSM states, default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package c2sif_pkg;

  localparam int ID_W_DEF        = 8;
  localparam int FN_W_DEF        = 4;
  localparam int DATA_W_DEF      = 32;
  localparam int RET_W_DEF       = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;

  localparam logic [FN_W_DEF-1:0]  FN_WRITE    = '0;
  localparam logic [FN_W_DEF-1:0]  FN_READ     = FN_W_DEF'(1);

  localparam logic [RET_W_DEF-1:0] RET_OK      = '0;
  localparam logic [RET_W_DEF-1:0] RET_TIMEOUT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    RESP = 2'd3
  } c2sif_mst_state_e;

endpackage

// File: rtl/c2sif_sync2.sv
// Two-flop synchronizer bringing the asynchronous c2sif ack into the clk domain.
// Latency: 2 clk cycles from d change to q change.
// Backpressure: none; free-running.
//
// Ports: clk - sampling clock; rst - async active-low reset (q clears to 0);
//        d - asynchronous input; q - synchronized output.
module c2sif_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/c2sif_master.sv
// c2sif request master: takes one host command, runs the four-phase req/ack handshake, returns ret/rdata.
// Latency: accept -> req in 1 cycle; ack_s rise -> req fall in 1 cycle; zero-delay driver gives rsp_valid 7 cycles after accept.
// Backpressure: cmd_ready only in IDLE (one outstanding transaction); response held until rsp_ready.
//
// Build option: define C2SIF_TIMEOUT_EN to enable the REQ/REL watchdog (TIMEOUT_CYC cycles,
// ends the transaction with RET_TIMEOUT and rsp_data=0). Without it REQ/REL wait indefinitely.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   cmd_valid/cmd_ready            host command handshake; cmd_id/cmd_fn/cmd_data payload
//   req, id, fn, data              c2sif bus toward drivers (id/fn/data held from accept through REL)
//   ack, ret, rdata                c2sif reply from the addressed driver (ack asynchronous)
//   rsp_valid/rsp_ready            response handshake; rsp_ret/rsp_data payload
module c2sif_master
  import c2sif_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int FN_W        = FN_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RET_W       = RET_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [FN_W-1:0]   cmd_fn,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              req,
  output logic [ID_W-1:0]   id,
  output logic [FN_W-1:0]   fn,
  output logic [DATA_W-1:0] data,
  input  logic              ack,
  input  logic [RET_W-1:0]  ret,
  input  logic [DATA_W-1:0] rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RET_W-1:0]  rsp_ret,
  output logic [DATA_W-1:0] rsp_data
);

  c2sif_mst_state_e state_q, state_d;

  logic              ack_s;
  logic              ld_cmd;
  logic              cap_rsp;
  logic              set_to;
  logic              wd_expire;
  logic              req_d, req_q;
  logic              rsp_vld_d, rsp_vld_q;
  logic [ID_W-1:0]   id_q;
  logic [FN_W-1:0]   fn_q;
  logic [DATA_W-1:0] data_q;
  logic [RET_W-1:0]  rsp_ret_q;
  logic [DATA_W-1:0] rsp_data_q;

  c2sif_sync2 u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // req and rsp_valid are registered (next values computed here) so they are glitch-free
  // and rsp_valid never follows rsp_ready combinationally.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    ld_cmd    = 1'b0;
    cap_rsp   = 1'b0;
    set_to    = 1'b0;
    req_d     = req_q;
    rsp_vld_d = rsp_vld_q;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ld_cmd  = 1'b1;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // A real ack wins over a watchdog expiry landing in the same cycle.
        if (ack_s) begin
          cap_rsp = 1'b1;
          req_d   = 1'b0;
          state_d = REL;
        end else if (wd_expire) begin
          set_to    = 1'b1;
          req_d     = 1'b0;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end
      end
      REL: begin
        if (!ack_s) begin
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end else if (wd_expire) begin
          // ack stuck high: the driver's captured reply is not trusted.
          set_to    = 1'b1;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        req_d     = 1'b0;
        rsp_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= 1'b0;
      rsp_vld_q  <= 1'b0;
      id_q       <= '0;
      fn_q       <= '0;
      data_q     <= '0;
      rsp_ret_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      req_q     <= req_d;
      rsp_vld_q <= rsp_vld_d;
      if (ld_cmd) begin
        id_q   <= cmd_id;
        fn_q   <= cmd_fn;
        data_q <= cmd_data;
      end
      if (cap_rsp) begin
        rsp_ret_q  <= ret;
        rsp_data_q <= rdata;
      end else if (set_to) begin
        rsp_ret_q  <= '1;  // RET_TIMEOUT, sized to RET_W
        rsp_data_q <= '0;
      end
    end
  end

`ifdef C2SIF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Restarts on every state change, so REQ and REL each get a full TIMEOUT_CYC budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if ((state_d != state_q) || !((state_q == REQ) || (state_q == REL))) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  assign req       = req_q;
  assign id        = id_q;
  assign fn        = fn_q;
  assign data      = data_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_ret   = rsp_ret_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_c2sif_master.sv
// Bench for c2sif_master: directed commands, behavioural c2sif driver, queue-based response scoreboard.
// Latency: n/a.
// Backpressure: rsp_ready is stalled in one scenario.
module tb_c2sif_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_id;
  logic [3:0]  cmd_fn;
  logic [31:0] cmd_data;
  logic        req;
  logic [7:0]  id;
  logic [3:0]  fn;
  logic [31:0] data;
  logic        ack;
  logic [7:0]  ret = 8'h00;
  logic [31:0] rdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_ret;
  logic [31:0] rsp_data;

  c2sif_master #(
    .ID_W(8), .FN_W(4), .DATA_W(32), .RET_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_fn(cmd_fn), .cmd_data(cmd_data),
    .req(req), .id(id), .fn(fn), .data(data),
    .ack(ack), .ret(ret), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ret(rsp_ret), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expected event not seen within bound", name);
  endtask

  // ---------------- behavioural driver ----------------
  logic        drv_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_delay = 0;
  int          drv_cnt = 0;
  logic [7:0]  drv_ret_val = 8'h00;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] din = 32'h0;
  int          ack_rise_cyc = 0;
  int          ack_req_lat = -1;

  assign ack = drv_ack | stray_ack;

  // Driver id 9 does not exist; every other id answers after ack_delay cycles.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      drv_ack = 1'b0;
      drv_cnt = 0;
    end else if (req && !drv_ack && id != 8'd9) begin
      if (drv_cnt >= ack_delay) begin
        ret   = drv_ret_val;
        rdata = (fn == 4'd1) ? rd_val : 32'h0;
        if (fn == 4'd0) din = data;
        drv_ack = 1'b1;
        ack_rise_cyc = cyc;
      end else begin
        drv_cnt++;
      end
    end else if (!req && drv_ack) begin
      ack_req_lat = cyc - ack_rise_cyc;
      drv_ack = 1'b0;
      drv_cnt = 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [7:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic        rsp_vld_d = 1'b0;
  int          rsp_first_cyc = -1;
  int          stab_err = 0;
  logic        hold_act = 1'b0;
  logic [43:0] hold_bus = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (rsp_valid && !rsp_vld_d) rsp_first_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_ret", {56'h0, rsp_ret}, {56'h0, e.r});
          chk("rsp_data", {32'h0, rsp_data}, {32'h0, e.d});
        end
      end
      if (req || ack) begin
        if (!hold_act) begin
          hold_bus = {id, fn, data};
          hold_act = 1'b1;
        end else if ({id, fn, data} !== hold_bus) begin
          stab_err++;
        end
      end else begin
        hold_act = 1'b0;
      end
    end
    rsp_vld_d = rsp_valid;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] i, input logic [3:0] f, input logic [31:0] d,
                      output int acc_cyc);
    logic ok;
    cmd_id = i; cmd_fn = f; cmd_data = d; cmd_valid = 1'b1;
    acc_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      ok = cmd_ready;
      if (ok) acc_cyc = cyc;
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (acc_cyc < 0) fail_now("cmd_accept");
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      fail_now(name);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int   acc;
    int   n;
    logic busy, saw_req, saw_rsp, got;

    rst = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_fn = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {61'h0, req, cmd_ready, rsp_valid}, 64'b010);
    chk("rst_bus",  {20'h0, id, fn, data}, 64'h0);
    chk("rst_rsp",  {24'h0, rsp_ret, rsp_data}, 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    tick(); tick();

    // 1: write id=3 data=1, driver acks after 2 cycles
    ack_delay = 2; drv_ret_val = 8'h00;
    exp_q.push_back({8'h00, 32'h0});
    send(8'd3, 4'd0, 32'h0000_0001, acc);
    @(negedge clk);
    chk("t1_req_rise", {63'h0, req}, 64'h1);
    chk("t1_req_lat", 64'(cyc - acc), 64'd1);
    wait_drain("t1_rsp");
    chk("t1_din", {32'h0, din}, 64'h1);
    chk("t1_ack_to_req_fall", 64'(ack_req_lat), 64'd3);

    // 2: read returns DEADBEEF, bus must hold steady
    ack_delay = 1; rd_val = 32'hDEAD_BEEF;
    exp_q.push_back({8'h00, 32'hDEAD_BEEF});
    send(8'd5, 4'd1, 32'h1234_5678, acc);
    @(negedge clk);
    chk("t2_bus", {20'h0, id, fn, data}, {20'h0, 8'd5, 4'd1, 32'h1234_5678});
    wait_drain("t2_rsp");
    chk("t2_stable", 64'(stab_err), 64'd0);

    // zero-delay driver: end-to-end latency, nonzero ret
    ack_delay = 0; drv_ret_val = 8'h5A;
    exp_q.push_back({8'h5A, 32'h0});
    send(8'd3, 4'd0, 32'hA5A5_0000, acc);
    wait_drain("lat_rsp");
    chk("lat_accept_rsp", 64'(rsp_first_cyc - acc), 64'd7);

    // 3: back-to-back with response stalled 5 cycles
    drv_ret_val = 8'h00; rd_val = 32'h0BAD_F00D; rsp_ready = 1'b0;
    exp_q.push_back({8'h00, 32'h0});
    send(8'd3, 4'd0, 32'h0000_0002, acc);
    exp_q.push_back({8'h00, 32'h0BAD_F00D});
    cmd_id = 8'd4; cmd_fn = 4'd1; cmd_data = 32'h0; cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) fail_now("t3_rsp_valid");
    busy = 1'b0;
    repeat (5) begin
      busy = busy | cmd_ready | req | !rsp_valid;
      @(negedge clk);
    end
    chk("t3_hold", {63'h0, busy}, 64'h0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_idle_after_hs", {62'h0, cmd_ready, req}, 64'b10);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_second_req", {62'h0, cmd_ready, req}, 64'b01);
    wait_drain("t3_rsp");

`ifdef C2SIF_TIMEOUT_EN
    // 4: no driver for id=9 -> watchdog
    exp_q.push_back({8'hFF, 32'h0});
    send(8'd9, 4'd0, 32'h0000_0007, acc);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!req) break;
      n++;
    end
    chk("t4_req_cycles", 64'(n), 64'd16);
    wait_drain("t4_rsp");
`endif

    // 5: reset while req=1 (id=9 never acks)
    send(8'd9, 4'd1, 32'h0000_0077, acc);
    repeat (5) tick();
`ifndef C2SIF_TIMEOUT_EN
    repeat (40) tick();
    @(negedge clk);
    chk("t5_no_watchdog", {62'h0, req, rsp_valid}, 64'b10);
`endif
    @(negedge clk);
    chk("t5_req_before_rst", {63'h0, req}, 64'h1);
    #2 rst = 1'b0;
    #1 chk("t5_async_rst", {61'h0, req, rsp_valid, cmd_ready}, 64'b001);
    @(posedge clk); #1 rst = 1'b1;
    tick();
    ack_delay = 1;
    exp_q.push_back({8'h00, 32'h0});
    send(8'd3, 4'd0, 32'h0000_0042, acc);
    wait_drain("t5_after_rst");
    chk("t5_din", {32'h0, din}, 64'h42);

    // 6: stray ack in IDLE
    tick();
    stray_ack = 1'b1; saw_req = 1'b0; saw_rsp = 1'b0;
    repeat (6) begin @(negedge clk); saw_req |= req; saw_rsp |= rsp_valid; end
    stray_ack = 1'b0;
    repeat (6) begin @(negedge clk); saw_req |= req; saw_rsp |= rsp_valid; end
    chk("t6_stray", {62'h0, saw_req, saw_rsp}, 64'b00);
    chk("t6_idle", {63'h0, cmd_ready}, 64'h1);
    tick();
    rd_val = 32'hCAFE_F00D; drv_ret_val = 8'h03;
    exp_q.push_back({8'h03, 32'hCAFE_F00D});
    send(8'd7, 4'd1, 32'h0, acc);
    wait_drain("t6_rsp");

    chk("stable_all", 64'(stab_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
